// File: rtl/data_sync_tx.sv
// rtl/data_sync_tx.sv - source-side launcher for the four-phase data synchronizer path
module data_sync_tx #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  dest_clk,
    input  logic                  dest_rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  bus_ack,
    output logic [DATA_WIDTH-1:0] unsync_bus,
    output logic                  bus_enable,
    output logic                  tx_done,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  ack_sync;
    logic                    ack_s;
    logic                    pend_valid;
    logic [DATA_WIDTH-1:0]   pend_data;
    logic                    accept;

    // ack arrives from another clock domain; only the last stage is trusted
    always_ff @(posedge dest_clk or negedge dest_rst) begin
        if (!dest_rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus_ack};
        end
    end

    assign ack_s    = ack_sync[SYNC_STAGES-1];
    assign tx_ready = ~pend_valid;
    assign accept   = tx_valid & ~pend_valid;
    assign busy     = (state != IDLE) | pend_valid;

    always_ff @(posedge dest_clk or negedge dest_rst) begin
        if (!dest_rst) begin
            state      <= IDLE;
            unsync_bus <= '0;
            bus_enable <= 1'b0;
            tx_done    <= 1'b0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    // a queued word always launches before any new offer
                    if (pend_valid) begin
                        unsync_bus <= pend_data;
                        pend_valid <= 1'b0;
                        bus_enable <= 1'b1;
                        state      <= REQ;
                    end else if (accept) begin
                        unsync_bus <= tx_data;
                        bus_enable <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (accept) begin
                        pend_data  <= tx_data;
                        pend_valid <= 1'b1;
                    end
                    if (ack_s) begin
                        bus_enable <= 1'b0;
                        tx_done    <= 1'b1;
                        state      <= RELEASE;
                    end
                end
                RELEASE: begin
                    // an accept on the exit edge still lands in the pending slot
                    if (accept) begin
                        pend_data  <= tx_data;
                        pend_valid <= 1'b1;
                    end
                    if (!ack_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_sync_tx.sv
// tb/tb_data_sync_tx.sv - table-driven and directed checks for data_sync_tx
module tb_data_sync_tx;

    logic       dest_clk = 1'b0;
    logic       dest_rst = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       bus_ack  = 1'b0;
    logic [7:0] unsync_bus;
    logic       bus_enable;
    logic       tx_done;
    logic       busy;

    int tests = 0;
    int fails = 0;

    data_sync_tx #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .dest_clk   (dest_clk),
        .dest_rst   (dest_rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .bus_ack    (bus_ack),
        .unsync_bus (unsync_bus),
        .bus_enable (bus_enable),
        .tx_done    (tx_done),
        .busy       (busy)
    );

    always #5 dest_clk = ~dest_clk;

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] d;
        logic       ack;
        logic [7:0] e_bus;
        logic       e_en;
        logic       e_done;
        logic       e_rdy;
        logic       e_busy;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] launch_log[$];
    int         done_cnt = 0;
    int         stab_err = 0;
    logic       prev_en  = 1'b0;
    logic [7:0] prev_bus = 8'h00;

    always @(negedge dest_clk) begin
        if (bus_enable && !prev_en) launch_log.push_back(unsync_bus);
        if (bus_enable && prev_en && unsync_bus != prev_bus) stab_err <= stab_err + 1;
        if (tx_done) done_cnt <= done_cnt + 1;
        prev_en  <= bus_enable;
        prev_bus <= unsync_bus;
    end

    task automatic add(input logic rst, input logic v, input logic [7:0] d, input logic ack,
                       input logic [7:0] eb, input logic een, input logic edn,
                       input logic erd, input logic ebz);
        vec_t r;
        r = '{rst, v, d, ack, eb, een, edn, erd, ebz};
        vecs.push_back(r);
    endtask

    task automatic add_n(input int n, input logic ack, input logic [7:0] eb, input logic een,
                         input logic edn, input logic erd, input logic ebz);
        for (int k = 0; k < n; k++) add(1'b1, 1'b0, 8'h00, ack, eb, een, edn, erd, ebz);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge dest_clk);
        #1;
    endtask

    // plays the receiver: waits for a request, acks it, then drops ack
    task automatic serve(input logic [7:0] exp);
        int n;
        n = 0;
        while (!bus_enable && n < 20) begin tick(); n++; end
        check("serve_req", {31'd0, bus_enable}, 32'd1);
        check("serve_data", {24'd0, unsync_bus}, {24'd0, exp});
        bus_ack = 1'b1;
        n = 0;
        while (!tx_done && n < 20) begin tick(); n++; end
        check("serve_done", {31'd0, tx_done}, 32'd1);
        bus_ack = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int errs;
        logic [7:0] exp_log[$];

        add(0, 1, 8'hA5, 0, 8'h00, 0, 0, 1, 0);
        add(0, 1, 8'hA5, 0, 8'h00, 0, 0, 1, 0);
        add(0, 1, 8'hA5, 0, 8'h00, 0, 0, 1, 0);
        add(1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0);
        // single transfer of 0x3C
        add(1, 1, 8'h3C, 0, 8'h3C, 1, 0, 1, 1);
        add_n(3, 0, 8'h3C, 1, 0, 1, 1);
        add_n(2, 1, 8'h3C, 1, 0, 1, 1);
        add_n(1, 1, 8'h3C, 0, 1, 1, 1);
        add_n(3, 1, 8'h3C, 0, 0, 1, 1);
        add_n(2, 0, 8'h3C, 0, 0, 1, 1);
        add_n(1, 0, 8'h3C, 0, 0, 1, 0);
        // back-to-back 0x11 then 0x22
        add(1, 1, 8'h11, 0, 8'h11, 1, 0, 1, 1);
        add(1, 1, 8'h22, 0, 8'h11, 1, 0, 0, 1);
        add_n(2, 1, 8'h11, 1, 0, 0, 1);
        add_n(1, 1, 8'h11, 0, 1, 0, 1);
        add_n(3, 0, 8'h11, 0, 0, 0, 1);
        add_n(1, 0, 8'h22, 1, 0, 1, 1);
        add_n(2, 1, 8'h22, 1, 0, 1, 1);
        add_n(1, 1, 8'h22, 0, 1, 1, 1);
        add_n(2, 0, 8'h22, 0, 0, 1, 1);
        add_n(1, 0, 8'h22, 0, 0, 1, 0);
        // spurious ack in IDLE
        add_n(3, 1, 8'h22, 0, 0, 1, 0);
        add_n(3, 0, 8'h22, 0, 0, 1, 0);
        // accept on the same edge as RELEASE exit
        add(1, 1, 8'h90, 0, 8'h90, 1, 0, 1, 1);
        add_n(2, 1, 8'h90, 1, 0, 1, 1);
        add_n(1, 1, 8'h90, 0, 1, 1, 1);
        add_n(2, 0, 8'h90, 0, 0, 1, 1);
        add(1, 1, 8'h91, 0, 8'h90, 0, 0, 0, 1);
        add_n(1, 0, 8'h91, 1, 0, 1, 1);
        add_n(2, 1, 8'h91, 1, 0, 1, 1);
        add_n(1, 1, 8'h91, 0, 1, 1, 1);
        add_n(2, 0, 8'h91, 0, 0, 1, 1);
        add_n(1, 0, 8'h91, 0, 0, 1, 0);

        #2;
        foreach (vecs[i]) begin
            dest_rst = vecs[i].rst;
            tx_valid = vecs[i].v;
            tx_data  = vecs[i].d;
            bus_ack  = vecs[i].ack;
            tick();
            check($sformatf("vec%0d", i),
                  {20'd0, unsync_bus, bus_enable, tx_done, tx_ready, busy},
                  {20'd0, vecs[i].e_bus, vecs[i].e_en, vecs[i].e_done, vecs[i].e_rdy, vecs[i].e_busy});
        end
        tx_valid = 1'b0;
        bus_ack  = 1'b0;

        // backpressure: 0x33 offered while 0xB2 is pending
        tx_valid = 1'b1; tx_data = 8'hA1; tick();
        tx_data = 8'hB2; tick();
        tx_data = 8'h33;
        check("bp_ready_low", {31'd0, tx_ready}, 32'd0);
        serve(8'hA1);
        check("bp_still_pend", {31'd0, tx_ready}, 32'd0);
        tick();
        check("bp_b2_launch", {23'd0, unsync_bus, bus_enable}, {23'd0, 8'hB2, 1'b1});
        check("bp_ready_back", {31'd0, tx_ready}, 32'd1);
        tick();
        check("bp_33_queued", {31'd0, tx_ready}, 32'd0);
        tx_valid = 1'b0;
        serve(8'hB2);
        serve(8'h33);
        check("bp_idle", {30'd0, busy, tx_ready}, 32'd1);

        // ack held high long after a transfer
        tx_valid = 1'b1; tx_data = 8'h44; tick();
        tx_valid = 1'b0;
        bus_ack = 1'b1;
        repeat (3) tick();
        check("held_done", {31'd0, tx_done}, 32'd1);
        errs = 0;
        repeat (50) begin
            tick();
            if (bus_enable !== 1'b0 || busy !== 1'b1 || unsync_bus !== 8'h44 || tx_done !== 1'b0)
                errs++;
        end
        check("held_release", errs, 0);
        bus_ack = 1'b0;
        repeat (3) tick();
        check("held_exit", {31'd0, busy}, 32'd0);

        // reset while in REQ with 0x77 pending
        tx_valid = 1'b1; tx_data = 8'h66; tick();
        tx_data = 8'h77; tick();
        tx_valid = 1'b0;
        check("mid_pend", {30'd0, tx_ready, bus_enable}, 32'd1);
        #2 dest_rst = 1'b0;
        #1;
        check("mid_rst_out", {20'd0, unsync_bus, bus_enable, tx_done, tx_ready, busy},
              {20'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
        tick();
        dest_rst = 1'b1;
        tick();
        tick();
        check("mid_pend_gone", {30'd0, bus_enable, busy}, 32'd0);
        tx_valid = 1'b1; tx_data = 8'h5A; tick();
        tx_valid = 1'b0;
        serve(8'h5A);
        check("post_rst_idle", {31'd0, busy}, 32'd0);

        exp_log = '{8'h3C, 8'h11, 8'h22, 8'h90, 8'h91, 8'hA1, 8'hB2, 8'h33, 8'h44, 8'h66, 8'h5A};
        tick();
        check("launch_count", launch_log.size(), exp_log.size());
        foreach (exp_log[i])
            if (i < launch_log.size())
                check($sformatf("launch%0d", i), {24'd0, launch_log[i]}, {24'd0, exp_log[i]});
        check("done_count", done_cnt, 10);
        check("bus_stable", stab_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_sync_tx.md
Name: data_sync_tx

Overview:
- Source-side launcher for the multi-clock data synchronizer path, clocked by dest_clk.
- Captures a word from a valid/ready interface and drives it on unsync_bus together with a level bus_enable.
- Runs a four-phase request/acknowledge handshake with the receiving domain, whose ack returns asynchronously. unsync_bus is held stable from launch until the ack has fully dropped.
- A one-entry pending buffer lets the upstream queue one word while a transfer is in flight.

Parameters:
DATA_WIDTH, 8, width of transferred word
SYNC_STAGES, 2, flops in the ack synchronizer chain (legal 2..4)

Ports:
dest_clk  input  1  block clock
dest_rst  input  1  reset, asynchronous, active-low
tx_data  input  DATA_WIDTH  word to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a word this cycle
bus_ack  input  1  asynchronous ack level from receiving domain
unsync_bus  output  DATA_WIDTH  launched data, stable during handshake
bus_enable  output  1  request level to receiving domain
tx_done  output  1  one-cycle pulse: receiver has captured the word
busy  output  1  high whenever state != IDLE or pending buffer is full

Behaviour:
- Reset values, all asynchronous on dest_rst low:
  - unsync_bus = 0, bus_enable = 0, tx_done = 0, tx_ready = 1, busy = 0.
  - Pending buffer empty; ack sync chain = 0; state = IDLE.
- Ack synchronizer: bus_ack passes through SYNC_STAGES flops to give ack_s. All handshake decisions use ack_s only.
- Accept rule:
  - A transfer is accepted when tx_valid and tx_ready are both high at a dest_clk edge.
  - tx_ready = !pend_valid, registered-equivalent with no combinational path from tx_valid.
- State machine (registered outputs):
  - IDLE:
    - If pend_valid: load unsync_bus <= pend_data, clear pend_valid, bus_enable <= 1, go to REQ.
    - Else if accept: load unsync_bus <= tx_data, bus_enable <= 1, go to REQ.
    - Latency: bus_enable is high in the cycle after the accept edge.
  - REQ: hold bus_enable = 1 and unsync_bus. On ack_s = 1: bus_enable <= 0, tx_done <= 1 for one cycle, go to RELEASE.
  - RELEASE: hold unsync_bus, bus_enable = 0. On ack_s = 0, go to IDLE.
- Pending buffer:
  - An accept when state != IDLE, or when IDLE with pend_valid, writes pend_data and sets pend_valid.
  - It cannot overflow because tx_ready is low while pend_valid is set.
- Simultaneous events:
  - In IDLE with pend_valid, tx_ready is low, so no new accept competes.
  - An accept in the same cycle as the RELEASE -> IDLE exit goes to the pending buffer, then launches from IDLE on the next edge.
- Data stability: unsync_bus changes only on the IDLE -> REQ edge and never while bus_enable = 1 or ack_s = 1.
- Ack rules:
  - An ack_s rising edge seen in IDLE or RELEASE is ignored.
  - An ack held high indefinitely keeps the block in RELEASE.
  - There is no timeout.
- Reset mid-transfer: all state and the pending word are discarded; outputs return to reset values immediately.
- Minimum transfer period with a receiver that acks within its own sync latency is about 2*SYNC_STAGES + 3 dest_clk cycles plus the receiver round-trip.

Test Plan:
- Reset: hold dest_rst = 0 with tx_valid = 1 and tx_data = 0xA5 -> unsync_bus = 0x00, bus_enable = 0, tx_ready = 1, tx_done = 0 throughout.
- Single transfer: send tx_data = 0x3C, then drive bus_ack high 4 cycles after bus_enable rises and low 4 cycles after it falls.
  - Expected: bus_enable rises 1 cycle after accept; tx_done pulses once 3 cycles after bus_ack rises (SYNC_STAGES = 2); busy clears 3 cycles after bus_ack falls.
  - unsync_bus stays 0x3C for the whole transfer.
- Back-to-back: send 0x11, then 0x22 while the first is in REQ.
  - Expected: tx_ready goes low after 0x22 is queued. 0x22 is launched the cycle after the first RELEASE exit; unsync_bus shows 0x11 then 0x22 only.
  - Two tx_done pulses.
- Ready backpressure: offer a third word 0x33 while pend_valid is set -> not accepted until pend drains; 0x33 is delivered third, with no loss or duplication.
- Spurious/held ack:
  - bus_ack pulsed while IDLE -> no tx_done, no state change.
  - bus_ack held high 50 cycles after a transfer -> block stays in RELEASE, no new launch, busy = 1.
- Reset mid-operation: assert dest_rst while in REQ with 0x77 pending -> outputs return to reset values immediately. After release, the block is IDLE, the pending word is gone, and a new transfer of 0x5A completes normally.
